// File: rtl/polar_enc_pkg.sv
// ============================================================================
// Module      : polar_enc_pkg
// Description : Elaboration-time helpers for the pipelined polar encoder
//               (stage count, frozen-mask popcount, info-to-u index map).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package polar_enc_pkg;

    localparam int c_MAX_N = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int popcount(input logic [c_MAX_N-1:0] mask);
        int cnt;
        cnt = 0;
        for (int i = 0; i < c_MAX_N; i++) begin
            cnt += int'(mask[i]);
        end
        return cnt;
    endfunction

    // Position in u of the j-th unfrozen index (ascending); -1 if absent.
    function automatic int info_index(input logic [c_MAX_N-1:0] mask,
                                      input int n, input int j);
        int cnt;
        int result;
        cnt    = 0;
        result = -1;
        for (int i = 0; i < c_MAX_N; i++) begin
            if (i < n && !mask[i]) begin
                if (cnt == j && result < 0) begin
                    result = i;
                end
                cnt++;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/polar_enc_stage.sv
// ============================================================================
// Module      : polar_enc_stage
// Description : One registered butterfly layer of the polar transform at
//               distance D, carrying a valid bit and holding when !i_adv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module polar_enc_stage #(
    parameter int N = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_adv,
    input  logic         i_valid,
    input  logic [N-1:0] i_data,
    output logic         o_valid,
    output logic [N-1:0] o_data
);

    logic [N-1:0] w_x;
    logic         r_valid;
    logic [N-1:0] r_data;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bfly
            if (((i / D) % 2) == 0) begin : g_upper
                assign w_x[i] = i_data[i] ^ i_data[i+D];
            end else begin : g_lower
                assign w_x[i] = i_data[i];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_data  <= w_x;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/polar_encoder_pipe.sv
// ============================================================================
// Module      : polar_encoder_pipe
// Description : Pipelined non-systematic polar encoder: frozen-bit mapper
//               register followed by log2(N) registered butterfly stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module polar_encoder_pipe
    import polar_enc_pkg::*;
#(
    parameter int           N           = 8,
    parameter int           K           = 4,
    parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] info_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] codeword
);

    localparam int                   c_STAGES   = clog2(N);
    localparam logic [c_MAX_N-1:0]   c_MASK_EXT = c_MAX_N'(FROZEN_MASK);

    generate
        if (N < 8 || N > c_MAX_N || (N & (N - 1)) != 0) begin : g_bad_n
            $error("polar_encoder_pipe: N must be a power of two in 8..64");
        end
        if (K < 1 || K > N) begin : g_bad_k
            $error("polar_encoder_pipe: K must be in 1..N");
        end
        if ((N - popcount(c_MASK_EXT)) != K) begin : g_bad_mask
            $error("polar_encoder_pipe: FROZEN_MASK zero count differs from K");
        end
    endgenerate

    logic                         w_adv;
    logic [N-1:0]                 w_u;
    logic [N-1:0]                 r_u;
    logic                         r_u_valid;
    logic [c_STAGES:0][N-1:0]     w_data;
    logic [c_STAGES:0]            w_valid;

    // The whole pipe moves only when the output slot is empty or draining.
    assign w_adv    = en && !(out_valid && !out_ready);
    assign in_ready = w_adv;

    genvar i, j, s;
    generate
        for (i = 0; i < N; i++) begin : g_frozen
            if (FROZEN_MASK[i]) begin : g_zero
                assign w_u[i] = 1'b0;
            end
        end
        for (j = 0; j < K; j++) begin : g_map
            localparam int c_IDX = info_index(c_MASK_EXT, N, j);
            assign w_u[c_IDX] = info_in[j];
        end
    endgenerate

    // Bubbles load zeros so idle stages carry deterministic data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_u_valid <= 1'b0;
            r_u       <= '0;
        end else if (w_adv) begin
            r_u_valid <= in_valid;
            r_u       <= in_valid ? w_u : '0;
        end
    end

    assign w_data[0]  = r_u;
    assign w_valid[0] = r_u_valid;

    generate
        for (s = 0; s < c_STAGES; s++) begin : g_stage
            polar_enc_stage #(
                .N (N),
                .D (1 << s)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_adv   (w_adv),
                .i_valid (w_valid[s]),
                .i_data  (w_data[s]),
                .o_valid (w_valid[s+1]),
                .o_data  (w_data[s+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[c_STAGES];
    assign codeword  = w_data[c_STAGES];

endmodule

`default_nettype wire

// File: tb/tb_polar_encoder_pipe.sv
// Scoreboard bench for polar_encoder_pipe: N=8 directed/random stream with
// stalls, en freeze and reset, plus an N=64 random-mask instance.
`timescale 1ns/1ps
`default_nettype none

module tb_polar_encoder_pipe;

    localparam int          N1    = 8;
    localparam int          K1    = 4;
    localparam logic [7:0]  MASK1 = 8'b0001_0111;
    localparam int          N2    = 64;
    localparam int          K2    = 32;
    localparam logic [63:0] MASK2 = 64'hA5C3_0F96_3C5A_F00F;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [K1-1:0] info_in;
    logic [N1-1:0] codeword;
    logic          in_valid2, in_ready2, out_valid2, out_ready2;
    logic [K2-1:0] info_in2;
    logic [N2-1:0] codeword2;

    always #5 clk = ~clk;

    polar_encoder_pipe #(.N(N1), .K(K1), .FROZEN_MASK(MASK1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .info_in(info_in),
        .out_valid(out_valid), .out_ready(out_ready), .codeword(codeword)
    );

    polar_encoder_pipe #(.N(N2), .K(K2), .FROZEN_MASK(MASK2)) dut64 (
        .clk(clk), .rst(rst), .en(1'b1),
        .in_valid(in_valid2), .in_ready(in_ready2), .info_in(info_in2),
        .out_valid(out_valid2), .out_ready(out_ready2), .codeword(codeword2)
    );

    typedef struct {
        logic [63:0] cw;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          go2   = 0;
    bit          done2 = 0;
    bit          prev_hold = 0;
    logic [7:0]  prev_cw   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: scatter info into unfrozen slots, then x_i = XOR of u_j over all j whose bits cover i.
    function automatic logic [63:0] ref_encode(input logic [63:0] mask, input int n,
                                               input logic [63:0] info);
        logic [63:0] u, x;
        int          j;
        u = '0; x = '0; j = 0;
        for (int i = 0; i < n; i++) begin
            if (!mask[i]) begin
                u[i] = info[j];
                j++;
            end
        end
        for (int i = 0; i < n; i++)
            for (int k = 0; k < n; k++)
                if ((k & i) == i) x[i] = x[i] ^ u[k];
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One input cycle on the N=8 instance; expected codeword pushed on acceptance.
    task automatic step(input bit v, input logic [3:0] info, input bit ordy, input bit e,
                        input logic [7:0] cw, input bit chk_lat);
        exp_t item;
        @(negedge clk);
        in_valid  = v;
        info_in   = info;
        out_ready = ordy;
        en        = e;
        #1;
        if (!e)        check("in_ready_en_low", {63'd0, in_ready}, 64'd0);
        else if (ordy) check("in_ready_open",   {63'd0, in_ready}, 64'd1);
        if (in_valid && in_ready) begin
            item.cw      = {56'd0, cw};
            item.acc     = cyc;
            item.chk_lat = chk_lat;
            q1.push_back(item);
        end
    endtask

    task automatic rand_step(input bit ordy_rand, input bit e);
        logic [3:0]  info;
        logic [63:0] x;
        info = 4'($urandom);
        x    = ref_encode({56'd0, MASK1}, N1, {60'd0, info});
        step(($urandom % 4) != 0, info, ordy_rand ? (($urandom % 3) != 0) : 1'b1, e, x[7:0], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b1, 1'b1, 8'd0, 1'b0);
    endtask

    // Async reset pulse between a rising edge and the next input cycle.
    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_codeword",  {56'd0, codeword},  64'd0);
        #1 rst = 1'b0;
        q1.delete();
        q2.delete();
        prev_hold = 0;
    endtask

    // Monitor for the N=8 instance.
    initial begin
        exp_t item;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (prev_hold) begin
                    check("stall_valid_held", {63'd0, out_valid}, 64'd1);
                    check("stall_cw_held",    {56'd0, codeword},  {56'd0, prev_cw});
                end
                if (out_valid && out_ready && en) begin
                    if (q1.size() == 0) begin
                        check("unexpected_output", {56'd0, codeword}, 64'hDEAD);
                    end else begin
                        item = q1.pop_front();
                        check("codeword", {56'd0, codeword}, item.cw);
                        if (item.chk_lat) check("latency", 64'(cyc - item.acc), 64'd4);
                    end
                end
                prev_hold = out_valid && !(out_ready && en);
                prev_cw   = codeword;
            end
        end
    end

    // Driver for the N=64 instance.
    initial begin
        exp_t        item;
        logic [31:0] info;
        wait (go2);
        while (!done2) begin
            @(negedge clk);
            info       = $urandom;
            in_valid2  = ($urandom % 4) != 0;
            info_in2   = info;
            out_ready2 = ($urandom % 3) != 0;
            #1;
            if (in_valid2 && in_ready2) begin
                item.cw      = ref_encode(MASK2, N2, {32'd0, info});
                item.acc     = cyc;
                item.chk_lat = 1'b0;
                q2.push_back(item);
            end
        end
        @(negedge clk);
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
    end

    // Monitor for the N=64 instance.
    initial begin
        exp_t item;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    check("unexpected_output64", codeword2, 64'hDEAD);
                end else begin
                    item = q2.pop_front();
                    check("codeword64", codeword2, item.cw);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; info_in = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; info_in2 = '0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_codeword",  {56'd0, codeword},  64'd0);
        check("reset_out_valid64", {63'd0, out_valid2}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        go2 = 1'b1;

        // Directed words from the known generator rows.
        step(1'b1, 4'b1111, 1'b1, 1'b1, 8'h96, 1'b1);
        idle(5);
        step(1'b1, 4'b1000, 1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 4'b0001, 1'b1, 1'b1, 8'h0F, 1'b1);
        idle(6);

        // Random stream with backpressure.
        for (int i = 0; i < 300; i++) rand_step(1'b1, 1'b1);

        // Enable dropped for three cycles mid-stream.
        for (int i = 0; i < 6; i++) rand_step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) rand_step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) rand_step(1'b1, 1'b1);
        idle(6);

        // Three words in flight, then reset.
        step(1'b1, 4'b0110, 1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b1, 4'b1010, 1'b1, 1'b1, 8'h00, 1'b0);
        step(1'b1, 4'b0101, 1'b1, 1'b1, 8'h00, 1'b0);
        in_valid = 1'b0;
        pulse_reset();
        idle(6);
        step(1'b1, 4'b1000, 1'b1, 1'b1, 8'hFF, 1'b1);
        idle(8);

        done2 = 1'b1;
        repeat (16) @(negedge clk);
        check("queue_empty8",  64'(q1.size()), 64'd0);
        check("queue_empty64", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
